difftest_step_scheduler: RTL and testbench

- Sits between SimTop's per-cycle `difftest_step` output and the host-side checker (DPI nstep wrapper or the emulation gfifo).
- Accumulates committed steps and issues batched nstep requests over a valid/ready channel, with at most one request outstanding.
- Applies backpressure to the DUT via `dut_stall` when the backlog grows too large.
- Latches checker failures and accumulator overflow as sticky errors that the testbench finishes on.

---
 rtl/difftest_sched_pkg.sv | 16 +
 rtl/step_accumulator.sv | 58 +++++
 rtl/difftest_step_scheduler.sv | 105 ++++++++++
 tb/tb_difftest_step_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_sched_pkg.sv
// difftest_sched_pkg: shared state type, batch width and batch-size helper for the step scheduler
//   sched_state_t : IDLE (accumulating), REQ (request presented), WAIT (response pending), FAIL (terminal)
//   NSTEP_W       : request size width for the default batch limit
//   min_batch     : steps to put in the next request
package difftest_sched_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FAIL} sched_state_t;

    localparam int MAX_BATCH_DEFAULT = 64;
    localparam int NSTEP_W = $clog2(MAX_BATCH_DEFAULT + 1);

    function automatic int unsigned min_batch(input int unsigned pending, input int unsigned max_batch);
        return (pending < max_batch) ? pending : max_batch;
    endfunction

endpackage

// File: rtl/step_accumulator.sv
// step_accumulator: saturating pending-step counter, sticky overflow flag and quiet-cycle counter
//   clock, reset  : clock and asynchronous active-low reset
//   step_in       : steps committed this cycle
//   fire, nstep   : request accepted this cycle and its size, removed from the backlog
//   pending       : registered un-issued step count
//   pending_next  : value pending takes at the next edge
//   ovf_event     : this cycle's update saturated
//   overflow      : sticky saturation flag
//   idle_expired  : IDLE_TIMEOUT quiet cycles seen with steps waiting
module step_accumulator #(
    parameter int STEP_WIDTH   = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int NSTEP_WIDTH  = 7,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STEP_WIDTH-1:0]  step_in,
    input  logic                   fire,
    input  logic [NSTEP_WIDTH-1:0] nstep,
    output logic [ACC_WIDTH-1:0]   pending,
    output logic [ACC_WIDTH-1:0]   pending_next,
    output logic                   ovf_event,
    output logic                   overflow,
    output logic                   idle_expired
);

    localparam int SW = ACC_WIDTH + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    logic [SW-1:0] sum;
    logic [IDLE_W-1:0] idle_cnt;

    // One extra bit catches the carry; nstep never exceeds pending, so the subtraction cannot borrow.
    always_comb begin
        sum = {1'b0, pending} + SW'(step_in) - (fire ? SW'(nstep) : SW'(0));
        ovf_event = sum[ACC_WIDTH];
        pending_next = ovf_event ? '1 : sum[ACC_WIDTH-1:0];
    end

    assign idle_expired = idle_cnt == IDLE_MAX;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= 1'b0;
            idle_cnt <= '0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow | ovf_event;
            // Quiet time only matters while something is waiting to be issued.
            idle_cnt <= (fire || step_in != '0) ? '0 :
                        (pending != '0 && idle_cnt < IDLE_MAX) ? idle_cnt + 1'b1 : idle_cnt;
        end
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// difftest_step_scheduler: batches committed difftest steps into nstep requests with one request in flight
//   clock, reset         : clock and asynchronous active-low reset
//   step_in              : steps committed by the DUT this cycle
//   flush                : drain request, issue partial batches immediately
//   req_valid/req_ready  : nstep request handshake, req_nstep = 1..MAX_BATCH
//   rsp_valid/rsp_fail   : checker result, one per accepted request
//   dut_stall            : registered backpressure to the DUT commit path
//   flush_done           : flush requested and nothing pending or in flight
//   fail, overflow       : sticky error flags
//   pending              : un-issued step count
module difftest_step_scheduler
    import difftest_sched_pkg::*;
#(
    parameter int STEP_WIDTH   = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int MAX_BATCH    = 64,
    parameter int STALL_THRESH = 192,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [STEP_WIDTH-1:0]            step_in,
    input  logic                             flush,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [$clog2(MAX_BATCH+1)-1:0]   req_nstep,
    input  logic                             rsp_valid,
    input  logic                             rsp_fail,
    output logic                             dut_stall,
    output logic                             flush_done,
    output logic                             fail,
    output logic                             overflow,
    output logic [ACC_WIDTH-1:0]             pending
);

    localparam int NW = $clog2(MAX_BATCH + 1);
    localparam logic [ACC_WIDTH-1:0] BATCH_LVL = ACC_WIDTH'(MAX_BATCH);
    localparam logic [ACC_WIDTH-1:0] STALL_LVL = ACC_WIDTH'(STALL_THRESH);

    sched_state_t state;
    logic fire;
    logic issue;
    logic to_fail;
    logic ovf_event;
    logic idle_expired;
    logic [ACC_WIDTH-1:0] pending_next;
    logic [NW-1:0] batch;

    step_accumulator #(
        .STEP_WIDTH  (STEP_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .NSTEP_WIDTH (NW),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_acc (
        .clock       (clock),
        .reset       (reset),
        .step_in     (step_in),
        .fire        (fire),
        .nstep       (req_nstep),
        .pending     (pending),
        .pending_next(pending_next),
        .ovf_event   (ovf_event),
        .overflow    (overflow),
        .idle_expired(idle_expired)
    );

    assign fire = state == REQ && req_ready;
    assign batch = NW'(min_batch(32'(pending), 32'(MAX_BATCH)));
    assign issue = pending >= BATCH_LVL || (pending != '0 && (idle_expired || flush));
    // Saturation, a response with nothing in flight, or a checker mismatch all end the run.
    assign to_fail = ovf_event || (rsp_valid && (state != WAIT || rsp_fail));
    assign flush_done = flush && state == IDLE && pending == '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_nstep <= '0;
            dut_stall <= 1'b0;
            fail      <= 1'b0;
        end else begin
            if (to_fail || state == FAIL) begin
                state     <= FAIL;
                req_valid <= 1'b0;
                fail      <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (issue) begin
                        state     <= REQ;
                        req_valid <= 1'b1;
                        req_nstep <= batch;
                    end
                    REQ: if (req_ready) begin
                        state     <= WAIT;
                        req_valid <= 1'b0;
                    end
                    WAIT: if (rsp_valid) state <= IDLE;
                    default: ;
                endcase
            end
            dut_stall <= pending_next >= STALL_LVL || to_fail || state == FAIL;
        end
    end

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// tb_difftest_step_scheduler: directed and randomized checks of the step scheduler against a behavioural model
module tb_difftest_step_scheduler;

    localparam int ACC_MAX = 65535;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_DEAD = 3;

    logic clock = 1'b0;
    logic reset, flush, req_ready, rsp_valid, rsp_fail;
    logic [7:0] step_in;
    logic req_valid, dut_stall, flush_done, fail, overflow;
    logic [6:0] req_nstep;
    logic [15:0] pending;

    logic s8_reset;
    logic [7:0] s8_step;
    logic o8_valid, o8_stall, o8_done, o8_fail, o8_overflow;
    logic [6:0] o8_nstep;
    logic [7:0] o8_pending;

    int n_cmp = 0;
    int n_bad = 0;
    int m_pend, m_idle, m_ph, m_nstep, rsp_wait;
    bit m_ovf, m_stall;

    always #5 clock = ~clock;

    difftest_step_scheduler u_dut (
        .clock(clock), .reset(reset), .step_in(step_in), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_nstep(req_nstep),
        .rsp_valid(rsp_valid), .rsp_fail(rsp_fail), .dut_stall(dut_stall),
        .flush_done(flush_done), .fail(fail), .overflow(overflow), .pending(pending)
    );

    difftest_step_scheduler #(.ACC_WIDTH(8)) u_dut8 (
        .clock(clock), .reset(s8_reset), .step_in(s8_step), .flush(1'b0),
        .req_valid(o8_valid), .req_ready(1'b0), .req_nstep(o8_nstep),
        .rsp_valid(1'b0), .rsp_fail(1'b0), .dut_stall(o8_stall),
        .flush_done(o8_done), .fail(o8_fail), .overflow(o8_overflow), .pending(o8_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_idle = 0; m_ph = PH_IDLE; m_nstep = 0; m_ovf = 0; m_stall = 0;
    endtask

    // One clock of the scheduler's rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        bit fire, ovf, bad, go;
        int sum;
        fire = m_ph == PH_REQ && req_ready;
        sum = m_pend + int'(step_in) - (fire ? m_nstep : 0);
        ovf = sum > ACC_MAX;
        bad = ovf || (rsp_valid && m_ph != PH_WAIT) || (rsp_valid && rsp_fail && m_ph == PH_WAIT);
        go = m_pend >= 64 || (m_pend > 0 && (m_idle >= 32 || flush));
        if (fire || step_in != 0) m_idle = 0;
        else if (m_pend > 0 && m_idle < 32) m_idle++;
        if (bad || m_ph == PH_DEAD) m_ph = PH_DEAD;
        else if (m_ph == PH_IDLE && go) begin
            m_ph = PH_REQ;
            m_nstep = m_pend < 64 ? m_pend : 64;
        end
        else if (m_ph == PH_REQ && req_ready) m_ph = PH_WAIT;
        else if (m_ph == PH_WAIT && rsp_valid) m_ph = PH_IDLE;
        m_ovf = m_ovf || ovf;
        m_pend = ovf ? ACC_MAX : sum;
        m_stall = m_pend >= 192 || m_ph == PH_DEAD;
    endtask

    task automatic check_outputs();
        check("req_valid", 32'(req_valid), 32'(m_ph == PH_REQ));
        if (m_ph == PH_REQ) check("req_nstep", 32'(req_nstep), m_nstep);
        check("dut_stall", 32'(dut_stall), 32'(m_stall));
        check("fail", 32'(fail), 32'(m_ph == PH_DEAD));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("pending", 32'(pending), m_pend);
    endtask

    task automatic cyc(input int st, input bit fl, input bit rdy, input bit rv, input bit rf);
        step_in = 8'(st); flush = fl; req_ready = rdy; rsp_valid = rv; rsp_fail = rf;
        #1 check("flush_done", 32'(flush_done), 32'(fl && m_ph == PH_IDLE && m_pend == 0));
        @(posedge clock);
        model_step();
        #1 check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0; step_in = '0; flush = 0; req_ready = 0; rsp_valid = 0; rsp_fail = 0;
        model_reset();
        #1;
        check("rst_req_valid", 32'(req_valid), 0);
        check("rst_req_nstep", 32'(req_nstep), 0);
        check("rst_dut_stall", 32'(dut_stall), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_flush_done", 32'(flush_done), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_ph, st;
        bit rv, rf;
        s8_reset = 1'b0;
        s8_step = '0;
        do_reset();

        // Burst to a full batch, accepted and answered cleanly
        repeat (8) cyc(8, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("burst_valid", 32'(req_valid), 1);
        check("burst_nstep", 32'(req_nstep), 64);
        cyc(0, 0, 1, 0, 0);
        check("burst_pend_after_fire", 32'(pending), 0);
        cyc(0, 0, 0, 1, 0);
        check("burst_fail_clear", 32'(fail), 0);

        // Partial batch after the quiet-time limit
        do_reset();
        cyc(5, 0, 0, 0, 0);
        repeat (32) cyc(0, 0, 0, 0, 0);
        check("tmo_not_yet", 32'(req_valid), 0);
        cyc(0, 0, 0, 0, 0);
        check("tmo_valid", 32'(req_valid), 1);
        check("tmo_nstep", 32'(req_nstep), 5);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);

        // Stall threshold boundary
        do_reset();
        cyc(191, 0, 0, 0, 0);
        check("stall_191", 32'(dut_stall), 0);
        cyc(1, 0, 0, 0, 0);
        check("stall_192", 32'(dut_stall), 1);

        // Backpressure with a large commit
        do_reset();
        cyc(255, 0, 0, 0, 0);
        check("bp_stall", 32'(dut_stall), 1);
        repeat (5) cyc(0, 0, 0, 0, 0);
        check("bp_bound", 32'(pending <= 16'd447), 1);
        check("bp_stall_hold", 32'(dut_stall), 1);
        check("bp_no_ovf", 32'(overflow), 0);

        // Steps arriving in the fire cycle, then flush of the remainder
        do_reset();
        cyc(70, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("conc_nstep", 32'(req_nstep), 64);
        cyc(3, 0, 1, 0, 0);
        check("conc_pend", 32'(pending), 9);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("flush_nstep", 32'(req_nstep), 9);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        check("flush_done_set", 32'(flush_done), 1);

        // Checker mismatch is terminal
        do_reset();
        cyc(100, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(100, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("mis_fail", 32'(fail), 1);
        check("mis_stall", 32'(dut_stall), 1);
        repeat (3) cyc(0, 0, 1, 0, 0);
        check("mis_no_req", 32'(req_valid), 0);
        check("mis_pend", 32'(pending), 136);
        do_reset();

        // Response with nothing outstanding
        cyc(0, 0, 0, 1, 0);
        check("proto_fail", 32'(fail), 1);
        do_reset();

        // Accumulator saturation on a narrow instance
        @(negedge clock);
        s8_reset = 1'b1;
        s8_step = 8'd255;
        @(posedge clock);
        #1 check("ovf8_first", 32'(o8_overflow), 0);
        check("ovf8_pend255", 32'(o8_pending), 255);
        @(posedge clock);
        #1 check("ovf8_flag", 32'(o8_overflow), 1);
        check("ovf8_fail", 32'(o8_fail), 1);
        check("ovf8_sat", 32'(o8_pending), 255);
        s8_step = '0;

        // Randomized traffic with a responding checker
        do_reset();
        rsp_wait = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 499) do_reset();
            if (m_stall || $urandom_range(0, 1) == 0) st = 0;
            else st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 8));
            rv = 0;
            rf = 0;
            if (m_ph == PH_WAIT) begin
                if (rsp_wait == 0) begin
                    rv = 1;
                    rf = $urandom_range(0, 99) == 0;
                end else rsp_wait--;
            end else rv = $urandom_range(0, 999) == 0;
            prev_ph = m_ph;
            cyc(st, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, rv, rf);
            if (m_ph == PH_WAIT && prev_ph != PH_WAIT) rsp_wait = int'($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
